// File: rtl/shift_engine_pkg.sv
// Shared types and op encodings for the multi-mode shift engine and its controllers.
package shift_engine_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_LSR  = 3'b001,
    OP_ASR  = 3'b010,
    OP_LSL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_NOP6 = 3'b110,
    OP_NOP7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Raw command codes for controller blocks that drive op as a plain vector.
  localparam logic [2:0] OP_CODE_LOAD = 3'b000;
  localparam logic [2:0] OP_CODE_LSR  = 3'b001;
  localparam logic [2:0] OP_CODE_ASR  = 3'b010;
  localparam logic [2:0] OP_CODE_LSL  = 3'b011;
  localparam logic [2:0] OP_CODE_ROR  = 3'b100;
  localparam logic [2:0] OP_CODE_ROL  = 3'b101;
  localparam logic [2:0] OP_CODE_NOP  = 3'b110;

  function automatic logic is_shift_op(input op_e o);
    return (o == OP_LSR) || (o == OP_ASR) || (o == OP_LSL) ||
           (o == OP_ROR) || (o == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: next register value and the bit leaving it.
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      OP_LSR: begin
        q_next  = {1'b0, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_LSL: begin
        q_next  = {q[WIDTH-2:0], 1'b0};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Sequential shift/rotate engine, one bit position per clock, start/ready/done handshake.
// Optional feature: define SHIFT_ENGINE_ABORT_EN to add an abort input.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef SHIFT_ENGINE_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_val,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             serial_q, serial_d;

  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             abort_w;
  op_e              op_in;

`ifdef SHIFT_ENGINE_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign op_in = op_e'(op);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .q       (q_q),
    .q_next  (step_q),
    .out_bit (step_bit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      cnt_q    <= '0;
      q_q      <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      serial_q <= serial_d;
    end
  end

  // Datapath updates ride along with the next-state decision; reset outranks abort via the flop block.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    serial_d = serial_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_in;
          cnt_d = amount;
          if (op_in == OP_LOAD) begin
            q_d     = load_val;
            state_d = ST_DONE;
          end else if (!is_shift_op(op_in) || (amount == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (abort_w) begin
          state_d = ST_IDLE;
        end else begin
          q_d      = step_q;
          serial_d = step_bit;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

  assign q          = q_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (WIDTH=8): vector table, scoreboard, corner sequences.
// Abort scenario is exercised when SHIFT_ENGINE_ABORT_EN is defined.
module tb_shift_engine;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             abort;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic [W-1:0]     load_val;
  logic             ready;
  logic             done;
  logic [W-1:0]     q;
  logic             serial_out;

  shift_engine #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef SHIFT_ENGINE_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .op         (op),
    .amount     (amount),
    .load_val   (load_val),
    .ready      (ready),
    .done       (done),
    .q          (q),
    .serial_out (serial_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] q;
    logic         s;
  } ms_t;

  typedef struct {
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic [W-1:0]     ld;
    logic [W-1:0]     eq;
    logic             es;
    int unsigned      lat;
  } vec_t;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  ms_t         sb[$];
  ms_t         cur;
  vec_t        tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: apply the command bit by bit with plain shift operators.
  function automatic ms_t model(input logic [2:0] mop, input int unsigned amt,
                                input logic [W-1:0] ld, input ms_t c);
    ms_t r = c;
    if (mop == 3'b000) begin
      r.q = ld;
    end else if (mop <= 3'b101) begin
      for (int unsigned i = 0; i < amt; i++) begin
        case (mop)
          3'b001:  begin r.s = r.q[0];   r.q = r.q >> 1; end
          3'b010:  begin r.s = r.q[0];   r.q = $signed(r.q) >>> 1; end
          3'b011:  begin r.s = r.q[W-1]; r.q = r.q << 1; end
          3'b100:  begin r.s = r.q[0];   r.q = {r.q[0], r.q[W-1:1]}; end
          default: begin r.s = r.q[W-1]; r.q = {r.q[W-2:0], r.q[W-1]}; end
        endcase
      end
    end
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding command.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        ms_t e;
        e = sb.pop_front();
        check("sb_q", {24'd0, q}, {24'd0, e.q});
        check("sb_serial", {31'd0, serial_out}, {31'd0, e.s});
      end
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic run_cmd(input logic [2:0] c_op, input logic [CNT_W-1:0] c_amt,
                         input logic [W-1:0] c_ld, input logic [W-1:0] e_q,
                         input logic e_s, input int unsigned e_lat, input bit poke);
    int unsigned cyc;
    ms_t e;
    wait_ready();
    e.q = e_q;
    e.s = e_s;
    sb.push_back(e);
    cur = e;
    start = 1'b1; op = c_op; amount = c_amt; load_val = c_ld;
    @(posedge clock); #1;
    start = 1'b0; op = 3'($urandom); amount = CNT_W'($urandom); load_val = W'($urandom);
    if (e_lat > 1) check("busy_ready", {31'd0, ready}, 32'd0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      if (poke && cyc == 2) begin
        start = 1'b1; op = 3'b000; load_val = 8'h00; amount = 4'd0;
      end
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    check("latency", cyc, e_lat);
    if (done !== 1'b1) sb.delete();
    @(posedge clock); #1;
    check("post_done", {30'd0, ready, done}, 32'b10);
  endtask

  initial begin
    reset_n = 1'b0; abort = 1'b0; start = 1'b0;
    op = 3'b000; amount = '0; load_val = '0;
    cur = '0;

    //            op      amt    ld     exp_q  exp_s lat
    tbl[0]  = '{3'b000, 4'd0,  8'hA5, 8'hA5, 1'b0, 1};
    tbl[1]  = '{3'b000, 4'd0,  8'h96, 8'h96, 1'b0, 1};
    tbl[2]  = '{3'b010, 4'd3,  8'h00, 8'hF2, 1'b1, 4};
    tbl[3]  = '{3'b000, 4'd0,  8'h96, 8'h96, 1'b1, 1};
    tbl[4]  = '{3'b001, 4'd3,  8'h00, 8'h12, 1'b1, 4};
    tbl[5]  = '{3'b000, 4'd0,  8'h81, 8'h81, 1'b1, 1};
    tbl[6]  = '{3'b101, 4'd9,  8'h00, 8'h03, 1'b1, 10};
    tbl[7]  = '{3'b000, 4'd0,  8'h81, 8'h81, 1'b1, 1};
    tbl[8]  = '{3'b011, 4'd8,  8'h00, 8'h00, 1'b1, 9};
    tbl[9]  = '{3'b000, 4'd0,  8'h5A, 8'h5A, 1'b1, 1};
    tbl[10] = '{3'b011, 4'd0,  8'hFF, 8'h5A, 1'b1, 1};
    tbl[11] = '{3'b110, 4'd5,  8'hFF, 8'h5A, 1'b1, 1};
    tbl[12] = '{3'b100, 4'd3,  8'h00, 8'h4B, 1'b0, 4};
    tbl[13] = '{3'b000, 4'd0,  8'h80, 8'h80, 1'b0, 1};
    tbl[14] = '{3'b010, 4'd15, 8'h00, 8'hFF, 1'b1, 16};
    tbl[15] = '{3'b000, 4'd0,  8'h7F, 8'h7F, 1'b1, 1};
    tbl[16] = '{3'b001, 4'd15, 8'h00, 8'h00, 1'b0, 16};
    tbl[17] = '{3'b111, 4'd3,  8'hAA, 8'h00, 1'b0, 1};
    tbl[18] = '{3'b000, 4'd0,  8'hFF, 8'hFF, 1'b0, 1};
    tbl[19] = '{3'b011, 4'd1,  8'h00, 8'hFE, 1'b1, 2};
    tbl[20] = '{3'b000, 4'd0,  8'h00, 8'h00, 1'b1, 1};

    repeat (2) @(posedge clock);
    #1;
    check("reset_q", {24'd0, q}, 32'h00);
    check("reset_ready_done", {30'd0, ready, done}, 32'b10);
    check("reset_serial", {31'd0, serial_out}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      run_cmd(tbl[i].op, tbl[i].amt, tbl[i].ld, tbl[i].eq, tbl[i].es, tbl[i].lat, 1'b0);
    end

    // A start pulsed mid-shift must not disturb the running LSR 3.
    run_cmd(3'b000, 4'd0, 8'h96, 8'h96, 1'b1, 1, 1'b0);
    run_cmd(3'b001, 4'd3, 8'h00, 8'h12, 1'b1, 4, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [2:0]       rop;
      logic [CNT_W-1:0] ramt;
      logic [W-1:0]     rld;
      ms_t              e;
      int unsigned      lat;
      rop  = 3'($urandom_range(0, 7));
      ramt = CNT_W'($urandom_range(0, 11));
      rld  = W'($urandom);
      e    = model(rop, ramt, rld, cur);
      lat  = (rop == 3'b000 || rop >= 3'b110 || ramt == 0) ? 1 : ramt + 1;
      run_cmd(rop, ramt, rld, e.q, e.s, lat, 1'b0);
    end

`ifdef SHIFT_ENGINE_ABORT_EN
    run_cmd(3'b000, 4'd0, 8'hF0, 8'hF0, cur.s, 1, 1'b0);
    start = 1'b1; op = 3'b001; amount = 4'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_q", {24'd0, q}, 32'h3C);
    check("abort_serial", {31'd0, serial_out}, 32'd0);
    check("abort_ready_done", {30'd0, ready, done}, 32'b10);
    repeat (4) begin @(posedge clock); #1; end
    check("abort_no_done", {31'd0, done}, 32'd0);
    cur = '{q: 8'h3C, s: 1'b0};
`endif

    // Reset landing during the second step of LSR 5: cleared state, no done pulse.
    run_cmd(3'b000, 4'd0, 8'hF0, 8'hF0, cur.s, 1, 1'b0);
    start = 1'b1; op = 3'b001; amount = 4'd5;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("midreset_q", {24'd0, q}, 32'h00);
    check("midreset_ready_done", {30'd0, ready, done}, 32'b10);
    check("midreset_serial", {31'd0, serial_out}, 32'd0);
    repeat (8) begin @(posedge clock); #1; end
    check("midreset_no_done", {31'd0, done}, 32'd0);
    cur = '0;
    run_cmd(3'b000, 4'd0, 8'h3C, 8'h3C, 1'b0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
